// File: rtl/idu_queue_pkg.sv
// Shared IDU definitions: opcode constants, instruction type codes, operand-mux
// encodings and the packed layout of a decoded queue entry.
package idu_queue_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    typedef enum logic [2:0] {
        TYPE_NULL = 3'd0,
        TYPE_R    = 3'd1,
        TYPE_I    = 3'd2,
        TYPE_S    = 3'd3,
        TYPE_B    = 3'd4,
        TYPE_U    = 3'd5,
        TYPE_J    = 3'd6
    } inst_type_e;

    typedef enum logic [1:0] {
        AM1_ZERO = 2'd0,
        AM1_RS1  = 2'd1,
        AM1_PC   = 2'd2
    } amux1_e;

    typedef enum logic [1:0] {
        AM2_ZERO = 2'd0,
        AM2_RS2  = 2'd1,
        AM2_IMM  = 2'd2
    } amux2_e;

    // XLEN-independent part of an entry; a full entry is {pc, imm, dec_fix_t}.
    typedef struct packed {
        logic [9:0]  func_eu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [6:0]  opcode;
        logic [11:0] csr_addr;
        inst_type_e  itype;
        amux1_e      amux1;
        amux2_e      amux2;
        logic [7:0]  wmask;
        logic        gpr_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic        csr_wen;
        logic        is_ecall;
        logic        is_mret;
        logic        illegal;
    } dec_fix_t;

    localparam int DEC_FIX_W = $bits(dec_fix_t);

    function automatic int dec_w(input int xlen);
        return 2 * xlen + DEC_FIX_W;
    endfunction

    localparam int DEC_W = dec_w(32);

endpackage

// File: rtl/idu_queue_if.sv
// Handshake bundle between IFU, the decode queue and EXU.
interface idu_queue_if #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) ();
    import idu_queue_pkg::*;

    localparam int ENTRY_W = dec_w(XLEN);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    // valid/ready: a beat transfers on a rising edge where valid && ready; the
    // producer holds valid and payload until then, and ready never depends on valid.
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    pc;
    logic [31:0]        inst;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [ENTRY_W-1:0] out_dec;
    logic [CNT_W-1:0]   count;

    modport master (
        output in_valid, pc, inst, flush, out_ready,
        input  in_ready, out_valid, out_dec, count
    );

    modport slave (
        input  in_valid, pc, inst, flush, out_ready,
        output in_ready, out_valid, out_dec, count
    );

endinterface

// File: rtl/idu_decoder.sv
// Purely combinational RV32I decode of one raw instruction into the fixed
// entry fields plus a sign-extended immediate.
module idu_decoder
    import idu_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    output dec_fix_t        o_fix,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0]         w_opc;
    logic [2:0]         w_f3;
    logic               w_sign;
    logic signed [31:0] w_imm32;

    assign w_opc  = i_inst[6:0];
    assign w_f3   = i_inst[14:12];
    assign w_sign = i_inst[31];
    assign o_imm  = XLEN'(w_imm32);

    always_comb begin
        o_fix          = '0;
        o_fix.rs1      = i_inst[19:15];
        o_fix.rs2      = i_inst[24:20];
        o_fix.rd       = i_inst[11:7];
        o_fix.func3    = w_f3;
        o_fix.opcode   = w_opc;
        o_fix.csr_addr = i_inst[31:20];
        o_fix.itype    = TYPE_NULL;
        o_fix.amux1    = AM1_ZERO;
        o_fix.amux2    = AM2_ZERO;
        o_fix.is_ecall = (i_inst == INST_ECALL);
        o_fix.is_mret  = (i_inst == INST_MRET);

        case (w_opc)
            OPC_LUI:    begin o_fix.itype = TYPE_U; o_fix.amux2 = AM2_IMM; end
            OPC_AUIPC:  begin o_fix.itype = TYPE_U; o_fix.amux1 = AM1_PC;  o_fix.amux2 = AM2_IMM; end
            OPC_JAL:    begin o_fix.itype = TYPE_J; o_fix.amux1 = AM1_PC;  o_fix.amux2 = AM2_IMM; end
            OPC_JALR:   begin o_fix.itype = TYPE_I; o_fix.amux1 = AM1_RS1; o_fix.amux2 = AM2_IMM; end
            OPC_BRANCH: begin o_fix.itype = TYPE_B; o_fix.amux1 = AM1_PC;  o_fix.amux2 = AM2_IMM; end
            OPC_LOAD:   begin o_fix.itype = TYPE_I; o_fix.amux1 = AM1_RS1; o_fix.amux2 = AM2_IMM;
                              o_fix.mem_ren = 1'b1; end
            OPC_STORE:  begin o_fix.itype = TYPE_S; o_fix.amux1 = AM1_RS1; o_fix.amux2 = AM2_IMM;
                              o_fix.mem_wen = 1'b1; end
            OPC_OPIMM:  begin o_fix.itype = TYPE_I; o_fix.amux1 = AM1_RS1; o_fix.amux2 = AM2_IMM; end
            OPC_OP:     begin o_fix.itype = TYPE_R; o_fix.amux1 = AM1_RS1; o_fix.amux2 = AM2_RS2; end
            OPC_SYSTEM: begin o_fix.itype = TYPE_I; o_fix.csr_wen = 1'b1; end
            OPC_FENCE:  begin o_fix.itype = TYPE_NULL; end
            default:    begin o_fix.illegal = 1'b1; end
        endcase

        o_fix.gpr_wen = o_fix.itype inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J};

        // Shift-immediates (func3 1 and 5) carry the arithmetic/logical select in func7.
        if (w_opc == OPC_OPIMM && w_f3 != 3'd1 && w_f3 != 3'd5) begin
            o_fix.func7 = 7'd0;
        end else begin
            o_fix.func7 = i_inst[31:25];
        end

        if (w_opc == OPC_OP || w_opc == OPC_OPIMM) begin
            o_fix.func_eu = {w_f3, o_fix.func7};
        end

        case (w_f3)
            3'd0:    o_fix.wmask = 8'h01;
            3'd1:    o_fix.wmask = 8'h03;
            3'd2:    o_fix.wmask = 8'h0F;
            default: o_fix.wmask = 8'h00;
        endcase

        case (o_fix.itype)
            TYPE_I:  w_imm32 = {{20{w_sign}}, i_inst[31:20]};
            TYPE_S:  w_imm32 = {{20{w_sign}}, i_inst[31:25], i_inst[11:7]};
            TYPE_B:  w_imm32 = {{19{w_sign}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            TYPE_U:  w_imm32 = {i_inst[31:12], 12'b0};
            TYPE_J:  w_imm32 = {{11{w_sign}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

endmodule

// File: rtl/idu_queue.sv
// Decode queue: decodes each accepted fetch beat and holds up to DEPTH
// entries in a circular buffer for EXU.
module idu_queue
    import idu_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic        clk,
    input  logic        rst,
    idu_queue_if.slave  bus
);

    localparam int ENTRY_W = dec_w(XLEN);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    dec_fix_t           w_fix;
    logic [XLEN-1:0]    w_imm;
    logic               w_push;
    logic               w_pop;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_live;

    idu_decoder #(.XLEN(XLEN)) u_dec (
        .i_inst (bus.inst),
        .o_fix  (w_fix),
        .o_imm  (w_imm)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // r_live holds in_ready low until the first edge after reset is released.
    assign bus.in_ready  = r_live && (r_count < CNT_W'(DEPTH)) && !bus.flush;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_dec   = r_mem[r_rptr];
    assign bus.count     = r_count;
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live  <= 1'b0;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_live <= 1'b1;
            if (bus.flush) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                if (w_push) r_wptr <= ptr_inc(r_wptr);
                if (w_pop)  r_rptr <= ptr_inc(r_rptr);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload is not reset; it is only observable through out_dec while count != 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.pc, w_imm, w_fix};
        end
    end

endmodule

// File: doc/idu_queue.md
IDU_QUEUE -- requirements
Module: idu_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of decoded-entry slots; power of two, minimum 1.
REQ-002 SHALL have parameter XLEN, default 32, width of pc and imm.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  IFU offers pc/inst.
REQ-006 SHALL have port in_ready  output  1  block accepts pc/inst this cycle.
REQ-007 SHALL have port pc  input  XLEN  fetch address.
REQ-008 SHALL have port inst  input  32  raw instruction.
REQ-009 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-010 SHALL have port out_valid  output  1  head entry is valid for EXU.
REQ-011 SHALL have port out_ready  input  1  EXU consumes head entry.
REQ-012 SHALL have port out_dec  output  DEC_W  packed decoded entry, layout from the shared package.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of held entries.

Function
REQ-014 SHALL decode from inst: rs1=[19:15], rs2=[24:20], rd=[11:7], func3=[14:12], opcode=[6:0], csr_addr=[31:20].
REQ-015 SHALL force func7 to 0 for opcode 0010011 with func3 in {0,2,3,4,6,7}; otherwise func7=inst[31:25].
REQ-016 SHALL set funcEU={func3,func7} for opcodes 0110011 and 0010011; otherwise 0.
REQ-017 SHALL generate sign-extended imm per RV32I type: I (0010011, 0000011, 1100111, 1110011), S, B, U, J; R-type imm=0.
REQ-018 SHALL set amux1: 0 for lui; 1 for OP-IMM, jalr, load, store, OP; 2 for auipc, jal, branch; otherwise 0.
REQ-019 SHALL set amux2: 1 for OP; 2 for lui, OP-IMM, jal, jalr, auipc, load, store, branch; otherwise 0.
REQ-020 SHALL set wmask from func3: 0->0x01, 1->0x03, 2->0x0F, others 0x00.
REQ-021 SHALL set gpr_wen for R, I, U and J types; mem_ren for opcode 0000011; mem_wen for 0100011; csr_wen for 1110011.
REQ-022 SHALL set is_ecall iff inst==0x00000073 and is_mret iff inst==0x30200073.
REQ-023 SHALL set illegal=1 for any opcode outside the RV32I/SYSTEM set; gpr_wen, mem_ren, mem_wen and csr_wen SHALL then be 0 (new behaviour).
REQ-024 SHALL push on in_valid&&in_ready, storing pc and all decoded fields of that cycle.
REQ-025 SHALL drive in_ready = (count<DEPTH) && !flush, with no combinational path from out_ready.
REQ-026 SHALL drive out_valid = (count!=0); out_dec SHALL be the oldest entry, stable while out_valid&&!out_ready.
REQ-027 SHALL pop on out_valid&&out_ready; a simultaneous push and pop SHALL leave count unchanged.
REQ-028 SHALL give a latency of exactly 1 cycle from push edge to out_valid; with DEPTH>=2 and out_ready held high, throughput SHALL be 1 entry per cycle.
REQ-029 SHALL wrap read and write pointers modulo DEPTH; count==DEPTH means full, count==0 means empty.
REQ-030 SHALL, on flush, clear count and both pointers at the next edge; flush SHALL take priority over a simultaneous push or pop.

Reset
REQ-031 SHALL, while rst==0, asynchronously force count, pointers, out_valid and in_ready to 0; payload storage is not reset.
REQ-032 SHALL discard all held entries on reset mid-operation and assert in_ready on the first edge after rst rises.

Structure
REQ-033 SHALL take opcode constants, type codes (NULL/R/I/S/B/U/J), amux encodings and the out_dec field layout and DEC_W from a shared idu package.
REQ-034 SHALL place the combinational decode in one sub-module, idu_decoder; idu_queue holds the storage, pointers and handshake.

Verification
REQ-035 SHALL check: push inst 0x00500093, pc 0x80000000 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, amux1=1, amux2=2, gpr_wen=1, illegal=0.
REQ-036 SHALL check: DEPTH=2, out_ready=1, 4 back-to-back pushes -> 4 pops on consecutive cycles, in original order.
REQ-037 SHALL check: out_ready=0, 3 pushes offered -> count=2, in_ready=0, third held by IFU; it is accepted the cycle after the first pop.
REQ-038 SHALL check: count=2 with flush and in_valid both high -> next cycle count=0, out_valid=0, nothing pushed.
REQ-039 SHALL check: inst 0x00000073 -> is_ecall=1, csr_wen=1; inst 0x0000007F -> illegal=1 with all enables 0.
REQ-040 SHALL check: rst low while count=1 -> out_valid=0 immediately; after release, the first push appears 1 cycle later.
